// File: rtl/split_head_sched.sv
// rtl/split_head_sched.sv - head-major word scheduler feeding the multi-head split stage
module split_head_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_LEN    = 128,
    parameter int HEAD_NUM   = 12,
    parameter int HEAD_DIM   = 64,
    parameter int LANES      = 16,
    parameter int NUM_WIDTH  = 4,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                          clk_p,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_WIDTH:0]            cfg_head_num,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic [LANES*DATA_WIDTH-1:0]   mem_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [NUM_WIDTH:0]            out_head,
    output logic [$clog2(SEQ_LEN)-1:0]    out_row,
    output logic                          out_last_head,
    output logic                          out_last
);
    localparam int WPH = HEAD_DIM / LANES;
    localparam int WPR = HEAD_NUM * WPH;
    localparam int HW  = NUM_WIDTH + 1;
    localparam int RW  = $clog2(SEQ_LEN);
    localparam int CW  = (WPH > 1) ? $clog2(WPH) : 1;
    localparam int DW  = LANES * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [HW-1:0]   cfg;
    logic [CW-1:0]   chunk;
    logic [RW-1:0]   row;
    logic [HW-1:0]   head;

    logic            inflight;
    logic [HW-1:0]   fl_head;
    logic [RW-1:0]   fl_row;
    logic            fl_last_head;
    logic            fl_last;

    logic [DW-1:0]   f_data      [2];
    logic [HW-1:0]   f_head      [2];
    logic [RW-1:0]   f_row       [2];
    logic            f_last_head [2];
    logic            f_last      [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    logic            pop;
    logic            issue_last_head;
    logic            issue_last;

    assign out_valid       = (count != 2'd0);
    assign pop             = out_valid && out_ready;
    assign issue_last_head = (row == RW'(SEQ_LEN - 1)) && (chunk == CW'(WPH - 1));
    assign issue_last      = issue_last_head && (head == cfg - HW'(1));

    // Slots already claimed (buffered + in flight) must stay within the 2-entry FIFO.
    assign mem_rd_en   = (state == RUN) &&
                         ((({1'b0, count} + {2'b00, inflight}) < 3'd2) || pop);
    assign mem_rd_addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(WPR)
                       + ADDR_WIDTH'(head) * ADDR_WIDTH'(WPH)
                       + ADDR_WIDTH'(chunk);

    assign out_data      = out_valid ? f_data[rd_ptr]      : '0;
    assign out_head      = out_valid ? f_head[rd_ptr]      : '0;
    assign out_row       = out_valid ? f_row[rd_ptr]       : '0;
    assign out_last_head = out_valid && f_last_head[rd_ptr];
    assign out_last      = out_valid && f_last[rd_ptr];

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            cfg   <= '0;
            chunk <= '0;
            row   <= '0;
            head  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cfg   <= cfg_head_num;
                    err   <= 1'b0;
                    chunk <= '0;
                    row   <= '0;
                    head  <= '0;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: if (cfg == '0 || cfg > HW'(HEAD_NUM)) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    state <= RUN;
                end
                RUN: if (mem_rd_en) begin
                    if (chunk == CW'(WPH - 1)) begin
                        chunk <= '0;
                        if (row == RW'(SEQ_LEN - 1)) begin
                            row  <= '0;
                            head <= head + HW'(1);
                        end else begin
                            row <= row + RW'(1);
                        end
                    end else begin
                        chunk <= chunk + CW'(1);
                    end
                    if (issue_last) state <= DRAIN;
                end
                // Finish in the same cycle the final word leaves so done follows its handshake.
                DRAIN: if (!inflight && (count == 2'd0 || (count == 2'd1 && pop))) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= 1'b0;
            fl_head      <= '0;
            fl_row       <= '0;
            fl_last_head <= 1'b0;
            fl_last      <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_data[i]      <= '0;
                f_head[i]      <= '0;
                f_row[i]       <= '0;
                f_last_head[i] <= 1'b0;
                f_last[i]      <= 1'b0;
            end
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                fl_head      <= head;
                fl_row       <= row;
                fl_last_head <= issue_last_head;
                fl_last      <= issue_last;
            end
            if (inflight) begin
                f_data[wr_ptr]      <= mem_rd_data;
                f_head[wr_ptr]      <= fl_head;
                f_row[wr_ptr]       <= fl_row;
                f_last_head[wr_ptr] <= fl_last_head;
                f_last[wr_ptr]      <= fl_last;
                wr_ptr              <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_split_head_sched.sv
// tb/tb_split_head_sched.sv - directed self-checking bench for split_head_sched
module tb_split_head_sched;
    logic         clk_p = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   cfg_head_num = '0;
    logic         busy, done, err, mem_rd_en;
    logic [12:0]  mem_rd_addr;
    logic [127:0] mem_rd_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [4:0]   out_head;
    logic [6:0]   out_row;
    logic         out_last_head, out_last;

    int n_cmp = 0;
    int n_bad = 0;

    split_head_sched dut (
        .clk_p(clk_p), .rst_n(rst_n), .start(start), .cfg_head_num(cfg_head_num),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_head(out_head), .out_row(out_row),
        .out_last_head(out_last_head), .out_last(out_last)
    );

    always #5 clk_p = ~clk_p;

    function automatic logic [127:0] mem_fn(input int a);
        logic [15:0] w;
        w = 16'(a);
        return {4{w ^ 16'h5A3C, w | 16'hC000}};
    endfunction

    always @(posedge clk_p) if (mem_rd_en) mem_rd_data <= mem_fn(int'(mem_rd_addr));

    // Word index r of a job: chunk fastest, then row, then head.
    function automatic int addr_of(input int r);
        return ((r / 4) % 128) * 48 + (r / 512) * 4 + (r % 4);
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode: 0 ready held high, 1 pseudo-random ready, 2 ready low for 50 cycles at word stall_at
    task automatic run_job(input int cfg, input int mode, input int exp_words,
                           input int stall_at, input int restart_at, input int reset_at);
        int issued = 0, recv = 0, first_k = -1, last_k = -1, done_k = -1;
        int stall_cnt = 0, max_out = 0;
        logic prev_stall = 1'b0, prev_rd = 1'b0, restarted = 1'b0;
        logic [127:0] prev_data = '0;
        @(negedge clk_p);
        start = 1'b1;
        cfg_head_num = 5'(cfg);
        out_ready = (mode != 1);
        for (int k = 1; k <= exp_words * 3 + 200; k++) begin
            @(negedge clk_p);
            start = 1'b0;
            if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
            else if (mode == 2 && recv >= stall_at && stall_cnt < 50) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else out_ready = 1'b1;
            if (restart_at >= 0 && recv == restart_at && !restarted) begin
                start = 1'b1;
                cfg_head_num = 5'd3;
                restarted = 1'b1;
            end
            if (reset_at >= 0 && recv == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("read_in_flight_at_reset", prev_rd, 1);
                check_eq("reset_ctrl_outputs",
                         {busy, done, err, mem_rd_en, mem_rd_addr, out_valid,
                          out_head, out_row, out_last_head, out_last}, 0);
                check_eq("reset_out_data", out_data, 0);
                return;
            end
            #1;
            if (k == 1) begin
                check_eq("busy_after_start", busy, 1);
                check_eq("err_cleared_on_start", err, 0);
            end
            if (mem_rd_en) begin
                check_eq("rd_addr", mem_rd_addr, 128'(addr_of(issued)));
                issued++;
            end
            prev_rd = mem_rd_en;
            if (mode == 2 && !out_ready && stall_cnt >= 2)
                check_eq("stall_no_read", mem_rd_en, 0);
            if (mode == 2 && !out_ready && stall_cnt == 50)
                check_eq("stall_buffered_words", 128'(issued - recv), 2);
            if (out_valid && first_k < 0) first_k = k;
            if (prev_stall) begin
                check_eq("stall_valid_held", out_valid, 1);
                check_eq("stall_data_held", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                check_eq("out_data", out_data, mem_fn(addr_of(recv)));
                check_eq("out_head", out_head, 128'(recv / 512));
                check_eq("out_row", out_row, 128'((recv / 4) % 128));
                check_eq("out_last_head", out_last_head,
                         128'(((recv / 4) % 128) == 127 && (recv % 4) == 3));
                check_eq("out_last", out_last, 128'(recv == exp_words - 1));
                recv++;
                if (recv == exp_words) last_k = k;
            end
            if (issued - recv > max_out) max_out = issued - recv;
            if (done) begin
                done_k = k;
                check_eq("busy_low_at_done", busy, 0);
                break;
            end
        end
        check_eq("word_count", 128'(recv), 128'(exp_words));
        check_eq("issue_count", 128'(issued), 128'(exp_words));
        check_eq("done_after_last", 128'(done_k), 128'(last_k + 1));
        check_eq("max_outstanding_le2", 128'(max_out <= 2), 1);
        if (mode == 0) begin
            check_eq("first_valid_latency", 128'(first_k), 4);
            check_eq("no_bubbles", 128'(last_k - first_k + 1), 128'(exp_words));
        end
    endtask

    task automatic run_err(input int cfg);
        int done_k = -1, reads = 0;
        @(negedge clk_p);
        start = 1'b1;
        cfg_head_num = 5'(cfg);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_p);
            start = (k == 2);
            #1;
            if (mem_rd_en) reads++;
            if (done) done_k = k;
            if (k == 3) check_eq("start_at_done_ignored", busy, 0);
        end
        start = 1'b0;
        check_eq("err_no_reads", 128'(reads), 0);
        check_eq("err_done_time", 128'(done_k), 2);
        check_eq("err_sticky", err, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk_p);
        #1;
        check_eq("rst_ctrl_outputs",
                 {busy, done, err, mem_rd_en, mem_rd_addr, out_valid,
                  out_head, out_row, out_last_head, out_last}, 0);
        check_eq("rst_out_data", out_data, 0);
        @(negedge clk_p);
        rst_n = 1'b1;

        run_job(12, 0, 6144, -1, -1, -1);
        run_job(1, 1, 512, -1, -1, -1);
        run_err(0);
        run_err(13);
        run_job(2, 2, 1024, 300, -1, -1);
        run_job(2, 0, 1024, -1, 100, -1);
        run_job(12, 0, 6144, -1, -1, 300);
        repeat (2) @(negedge clk_p);
        rst_n = 1'b1;
        run_job(12, 0, 6144, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/split_head_sched.md
Name: split_head_sched

Overview:
- Scheduler that feeds the multi-head split stage.
- Reads a [SEQ_LEN x HEAD_NUM*HEAD_DIM] activation matrix from a row-major word SRAM. Each word holds LANES elements.
- Re-emits the words in head-major order (head, then row, then chunk) on a valid/ready stream, tagged with head and row indices.
- Sits between the QKV projection buffer and the per-head attention engines.
- Replaces a fully flattened combinational split with a one-word-per-cycle sequenced transfer.

Parameters:
- DATA_WIDTH, 8, element width in bits
- SEQ_LEN, 128, rows (tokens)
- HEAD_NUM, 12, maximum heads
- HEAD_DIM, 64, elements per head per row
- LANES, 16, elements per SRAM word; HEAD_DIM must be a multiple of LANES
- NUM_WIDTH, 4, head-count config is NUM_WIDTH+1 bits
- ADDR_WIDTH, 13, SRAM word address width; must satisfy 2^ADDR_WIDTH >= SEQ_LEN*HEAD_NUM*HEAD_DIM/LANES

Ports:
- clk_p, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle start request; ignored while busy
- cfg_head_num, in, NUM_WIDTH+1, heads to emit (legal 1..HEAD_NUM); sampled with start
- busy, out, 1, high from the cycle after an accepted start until done
- done, out, 1, one-cycle pulse at job end (normal or error)
- err, out, 1, sticky illegal-config flag; cleared by the next accepted start
- mem_rd_en, out, 1, SRAM read strobe
- mem_rd_addr, out, ADDR_WIDTH, SRAM word address
- mem_rd_data, in, LANES*DATA_WIDTH, read data; valid the cycle after mem_rd_en
- out_valid, out, 1, stream valid
- out_ready, in, 1, stream ready
- out_data, out, LANES*DATA_WIDTH, word payload
- out_head, out, NUM_WIDTH+1, head index of word
- out_row, out, clog2(SEQ_LEN), row index of word
- out_last_head, out, 1, last word of current head tile
- out_last, out, 1, last word of job

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters, FIFO and in-flight tracker cleared.
- Derived constants:
  - WPH = HEAD_DIM/LANES
  - WPR = HEAD_NUM*WPH
  - address = row*WPR + head*WPH + chunk
- Issue order: chunk fastest, then row, then head. Example for defaults: 0,1,2,3,48,49,50,51,... then 4,5,6,7,52,... for head 1.
- FSM states and transitions:
  - IDLE: start=1 moves to CHECK; start=0 stays in IDLE.
  - CHECK: one cycle.
    - cfg 0 or > HEAD_NUM: set err, go to DONE; no reads are issued.
    - Otherwise go to RUN.
  - RUN: issue reads until the final address has been issued, then go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
  - DONE: pulse done for one cycle, return to IDLE.
- busy is high in CHECK, RUN and DRAIN.
- Buffering:
  - 2-entry output FIFO; out_* fields are driven from its head entry.
  - One in-flight read at most per cycle; read data is always written into the FIFO the cycle it returns.
- Read issue rule (RUN only): mem_rd_en = (fifo_count + inflight < 2) OR (out_valid AND out_ready). This guarantees the FIFO never overflows and sustains 1 word/cycle when out_ready is held high.
- Latency: start accepted in cycle T gives:
  - CHECK at T+1
  - first mem_rd_en at T+2
  - data into the FIFO at end of T+3
  - first out_valid at T+4
- out_valid stays high and out_* stay stable while out_ready=0 (AXI-style); a transfer occurs on out_valid AND out_ready.
- Per-word tags:
  - out_head and out_row travel with the data.
  - out_last_head=1 on row SEQ_LEN-1, chunk WPH-1.
  - out_last=1 additionally requires head = cfg-1.
- done pulses in the cycle after the final word's handshake; busy falls in that same cycle.
- start while busy: ignored, cfg is not resampled.
- start coincident with the done pulse: ignored; start is accepted only in IDLE.
- Reset mid-operation: everything returns to reset values immediately; a read returning after reset is discarded.
- err is not cleared by done; only reset or the next accepted start clears it.

Test Plan:
- cfg=12, out_ready=1, start at T: first 8 addresses 0,1,2,3,48,49,50,51; first out_valid at T+4; 6144 words with no bubbles; out_last on word 6144 with out_head=11, out_row=127; done one cycle later.
- cfg=1, out_ready toggled pseudo-randomly: exactly 512 words, all out_head=0; data matches the SRAM model; payload stable during stalls; never more than 2 reads outstanding ahead of consumption.
- cfg=0, then cfg=13: no mem_rd_en; err=1; done pulses at T+2; second start with cfg=2 clears err and runs 1024 words.
- out_ready=0 for 50 cycles mid-run: exactly 2 words buffered, mem_rd_en held low, then resumes with no loss or duplicate.
- start pulsed again at word 100 with cfg=3: ignored; job still emits the original count.
- rst_n asserted at word 300 with a read in flight: all outputs 0 immediately; a new start with cfg=12 produces a clean sequence from address 0.
